rv32i_lsu_ctrl: RTL and testbench

- Load/store sequencer between the RV32I core's execute stage and a single 32-bit word-addressed memory bus.
- Accepts one decoded memory op (OP_LOAD/OP_STORE plus F3_LB..F3_SW from the RV32I package).
- Checks funct3 and alignment, generates byte lanes and replicated write data, and runs the req/ack handshake with timeout.
- Returns sign- or zero-extended load data with a one-cycle done pulse.

---
 rtl/RV32I.sv | 17 +
 rtl/rv32i_lsu_ctrl_if.sv | 22 ++
 rtl/rv32i_lsu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rv32i_lsu_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/RV32I.sv
// RV32I encodings used by the load/store path: opcode[6:2] and funct3 values.
package RV32I;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/rv32i_lsu_ctrl_if.sv
// Word-addressed memory bus between the LSU sequencer (master) and memory (slave).
interface rv32i_lsu_ctrl_if;

  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_mask_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  modport master (
    output bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out,
    input  bus_ack_in, bus_rdata_in
  );

  modport slave (
    input  bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out,
    output bus_ack_in, bus_rdata_in
  );

endinterface

// File: rtl/rv32i_lsu_ctrl.sv
// RV32I load/store sequencer: validates one memory op, runs a req/ack bus
// transaction with timeout, and returns extended load data with a done pulse.
module rv32i_lsu_ctrl
  import RV32I::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_in,
  input  logic [4:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        fault_out,
  output logic [31:0] rdata_out,
  rv32i_lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;

  logic        is_load, is_store, f3_ok, aligned, op_ok, accept;
  logic [3:0]  mask_new;
  logic [31:0] wdata_new, shifted, load_ext;

  // Decode of the op presented on the core side; only consumed when accepted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    is_load   = (opcode_in == OP_LOAD);
    is_store  = (opcode_in == OP_STORE);
    f3_ok     = 1'b0;
    aligned   = 1'b0;
    mask_new  = 4'b0000;
    wdata_new = 32'h0;
    if (is_load)
      f3_ok = funct3_in inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else if (is_store)
      f3_ok = funct3_in inside {F3_SB, F3_SH, F3_SW};
    case (funct3_in[1:0])
      2'b00: begin
        aligned   = 1'b1;
        mask_new  = 4'b0001 << addr_in[1:0];
        wdata_new = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr_in[0];
        mask_new  = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_in[15:0]}};
      end
      default: begin
        aligned   = (addr_in[1:0] == 2'b00);
        mask_new  = 4'b1111;
        wdata_new = wdata_in;
      end
    endcase
    if (is_load) wdata_new = 32'h0;
    op_ok  = f3_ok && aligned;
    accept = (state_q == S_IDLE) && start_in;
  end

  // Lane-shift and extend the returned word using the op latched at accept.
  always_comb begin
    shifted = bus.bus_rdata_in >> {off_q, 3'b000};
    case (f3_q)
      F3_LB:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_ext = {24'h0, shifted[7:0]};
      F3_LHU:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state logic; an ack in the expiring cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = 8'h0;
        if (start_in) state_d = op_ok ? S_REQ : S_FAULT;
      end
      S_REQ: begin
        if (bus.bus_ack_in)              state_d = S_DONE;
        else if (timer_q == TIMEOUT_LAST) state_d = S_FAULT;
        else                             timer_d = timer_q + 8'h1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: all outputs are registered, decoded from the next state.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE) || (state_d == S_FAULT);
    fault_d = (state_d == S_FAULT);
    req_d   = (state_d == S_REQ);
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = 32'h0;
      if (op_ok) begin
        we_d    = is_store;
        addr_d  = {addr_in[31:2], 2'b00};
        wdata_d = wdata_new;
        mask_d  = mask_new;
        ld_d    = is_load;
        f3_d    = funct3_in;
        off_d   = addr_in[1:0];
      end
    end
    if ((state_q == S_REQ) && bus.bus_ack_in && ld_q) rdata_d = load_ext;
  end

  // NOTE: the reset is synchronous and clears every flop; there is no memory array to exempt.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= S_IDLE;
      timer_q <= 8'h0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign fault_out         = fault_q;
  assign rdata_out         = rdata_q;
  assign bus.bus_req_out   = req_q;
  assign bus.bus_we_out    = we_q;
  assign bus.bus_addr_out  = addr_q;
  assign bus.bus_wdata_out = wdata_q;
  assign bus.bus_mask_out  = mask_q;

endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
// Directed self-checking bench for rv32i_lsu_ctrl: loads, stores, faults,
// timeout boundary, back-to-back ops and reset during a transaction.
module tb_rv32i_lsu_ctrl;

  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] STORE = 5'b01000;

  logic        clock;
  logic        reset;
  logic        start_in;
  logic [4:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        busy_out;
  logic        done_out;
  logic        fault_out;
  logic [31:0] rdata_out;

  int checks = 0;
  int passed = 0;

  rv32i_lsu_ctrl_if bus ();

  rv32i_lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start_in  (start_in),
    .opcode_in (opcode_in),
    .funct3_in (funct3_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .fault_out (fault_out),
    .rdata_out (rdata_out),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // After tick, the bench is in the cycle following the edge: outputs are sampled, inputs driven.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    start_in  = 1'b1;
    opcode_in = op;
    funct3_in = f3;
    addr_in   = addr;
    wdata_in  = wd;
    tick();
    start_in  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else passed++;
    checks++; if (done_out !== 1'b0) $display("FAIL rst_done: got %b want 0", done_out); else passed++;
    checks++; if (fault_out !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault_out); else passed++;
    checks++; if (rdata_out !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata_out); else passed++;
    checks++; if (bus.bus_req_out !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.bus_req_out); else passed++;
    checks++; if ({bus.bus_we_out, bus.bus_mask_out} !== 5'h0) $display("FAIL rst_we_mask: got %h want 0", {bus.bus_we_out, bus.bus_mask_out}); else passed++;
    checks++; if ({bus.bus_addr_out, bus.bus_wdata_out} !== 64'h0) $display("FAIL rst_addr_wdata: got %h want 0", {bus.bus_addr_out, bus.bus_wdata_out}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_lb_immediate;
    bus.bus_rdata_in = 32'h80FF_FF7F;
    bus.bus_ack_in   = 1'b1;
    issue(LOAD, 3'b000, 32'h0000_1003, 32'h0);
    checks++; if (bus.bus_req_out !== 1'b1) $display("FAIL lb_req: got %b want 1", bus.bus_req_out); else passed++;
    checks++; if (bus.bus_addr_out !== 32'h0000_1000) $display("FAIL lb_addr: got %h want 00001000", bus.bus_addr_out); else passed++;
    checks++; if (bus.bus_mask_out !== 4'b1000) $display("FAIL lb_mask: got %b want 1000", bus.bus_mask_out); else passed++;
    checks++; if (bus.bus_we_out !== 1'b0) $display("FAIL lb_we: got %b want 0", bus.bus_we_out); else passed++;
    checks++; if (bus.bus_wdata_out !== 32'h0) $display("FAIL lb_wdata: got %h want 0", bus.bus_wdata_out); else passed++;
    checks++; if (done_out !== 1'b0) $display("FAIL lb_early_done: got %b want 0", done_out); else passed++;
    tick();
    checks++; if (done_out !== 1'b1) $display("FAIL lb_done: got %b want 1", done_out); else passed++;
    checks++; if (fault_out !== 1'b0) $display("FAIL lb_fault: got %b want 0", fault_out); else passed++;
    checks++; if (rdata_out !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h want ffffff80", rdata_out); else passed++;
    checks++; if (bus.bus_req_out !== 1'b0) $display("FAIL lb_req_drop: got %b want 0", bus.bus_req_out); else passed++;
    bus.bus_ack_in = 1'b0;
    tick();
    checks++; if ({busy_out, done_out} !== 2'b00) $display("FAIL lb_idle: got %b want 00", {busy_out, done_out}); else passed++;
    checks++; if (rdata_out !== 32'hFFFF_FF80) $display("FAIL lb_rdata_hold: got %h want ffffff80", rdata_out); else passed++;
  endtask

  task automatic test_lhu_wait;
    bus.bus_rdata_in = 32'hBEEF_1234;
    bus.bus_ack_in   = 1'b0;
    issue(LOAD, 3'b101, 32'h0000_2002, 32'h0);
    checks++; if (bus.bus_mask_out !== 4'b1100) $display("FAIL lhu_mask: got %b want 1100", bus.bus_mask_out); else passed++;
    tick();
    tick();
    tick();
    checks++; if ({bus.bus_req_out, done_out} !== 2'b10) $display("FAIL lhu_waiting: got %b want 10", {bus.bus_req_out, done_out}); else passed++;
    bus.bus_ack_in = 1'b1;
    tick();
    checks++; if ({done_out, fault_out} !== 2'b10) $display("FAIL lhu_done: got %b want 10", {done_out, fault_out}); else passed++;
    checks++; if (rdata_out !== 32'h0000_BEEF) $display("FAIL lhu_rdata: got %h want 0000beef", rdata_out); else passed++;
    bus.bus_ack_in = 1'b0;
    tick();
  endtask

  task automatic test_stores;
    bus.bus_ack_in = 1'b0;
    issue(STORE, 3'b000, 32'h0000_0011, 32'h1234_56A5);
    checks++; if (bus.bus_we_out !== 1'b1) $display("FAIL sb_we: got %b want 1", bus.bus_we_out); else passed++;
    checks++; if (bus.bus_mask_out !== 4'b0010) $display("FAIL sb_mask: got %b want 0010", bus.bus_mask_out); else passed++;
    checks++; if (bus.bus_wdata_out !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", bus.bus_wdata_out); else passed++;
    checks++; if (bus.bus_addr_out !== 32'h0000_0010) $display("FAIL sb_addr: got %h want 00000010", bus.bus_addr_out); else passed++;
    bus.bus_ack_in = 1'b1;
    tick();
    checks++; if ({done_out, fault_out} !== 2'b10) $display("FAIL sb_done: got %b want 10", {done_out, fault_out}); else passed++;
    bus.bus_ack_in = 1'b0;
    tick();
    issue(STORE, 3'b001, 32'h0000_0102, 32'hCAFE_BEEF);
    checks++; if (bus.bus_mask_out !== 4'b1100) $display("FAIL sh_mask: got %b want 1100", bus.bus_mask_out); else passed++;
    checks++; if (bus.bus_wdata_out !== 32'hBEEF_BEEF) $display("FAIL sh_wdata: got %h want beefbeef", bus.bus_wdata_out); else passed++;
    checks++; if (bus.bus_addr_out !== 32'h0000_0100) $display("FAIL sh_addr: got %h want 00000100", bus.bus_addr_out); else passed++;
    bus.bus_ack_in = 1'b1;
    tick();
    bus.bus_ack_in = 1'b0;
    tick();
  endtask

  task automatic test_faults;
    logic [4:0]  ops  [4] = '{STORE, LOAD, LOAD, 5'b00100};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b011, 3'b001, 3'b000};
    logic [31:0] adrs [4] = '{32'h6, 32'h40, 32'h201, 32'h40};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
      checks++; if ({done_out, fault_out, bus.bus_req_out} !== 3'b110) $display("FAIL fault_%0d: done/fault/req got %b want 110", i, {done_out, fault_out, bus.bus_req_out}); else passed++;
      checks++; if (rdata_out !== 32'h0) $display("FAIL fault_rdata_%0d: got %h want 0", i, rdata_out); else passed++;
      tick();
      checks++; if ({busy_out, done_out, bus.bus_req_out} !== 3'b000) $display("FAIL fault_after_%0d: got %b want 000", i, {busy_out, done_out, bus.bus_req_out}); else passed++;
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int done_at    = 0;
    logic fault_seen = 1'b0;
    logic [31:0] rdata_seen = 32'hDEAD_BEEF;
    bus.bus_ack_in   = 1'b0;
    bus.bus_rdata_in = 32'h1111_1111;
    start_in  = 1'b1;
    opcode_in = LOAD;
    funct3_in = 3'b010;
    addr_in   = 32'h0000_0040;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      tick();
      start_in = 1'b0;
      if (bus.bus_req_out === 1'b1) req_cycles++;
      if (done_out === 1'b1) begin
        done_at    = i;
        fault_seen = fault_out;
        rdata_seen = rdata_out;
      end
    end
    checks++; if (done_at !== 17) $display("FAIL to_done_cycle: got %0d want 17", done_at); else passed++;
    checks++; if (req_cycles !== 16) $display("FAIL to_req_cycles: got %0d want 16", req_cycles); else passed++;
    checks++; if (fault_seen !== 1'b1) $display("FAIL to_fault: got %b want 1", fault_seen); else passed++;
    checks++; if (rdata_seen !== 32'h0) $display("FAIL to_rdata: got %h want 0", rdata_seen); else passed++;
    tick();
  endtask

  task automatic test_ack_at_timeout;
    bus.bus_ack_in   = 1'b0;
    bus.bus_rdata_in = 32'h1357_9BDF;
    issue(LOAD, 3'b010, 32'h0000_0080, 32'h0);
    for (int i = 2; i <= 16; i++) tick();
    checks++; if ({bus.bus_req_out, done_out} !== 2'b10) $display("FAIL ackto_req16: got %b want 10", {bus.bus_req_out, done_out}); else passed++;
    bus.bus_ack_in = 1'b1;
    tick();
    checks++; if ({done_out, fault_out} !== 2'b10) $display("FAIL ackto_done: got %b want 10", {done_out, fault_out}); else passed++;
    checks++; if (rdata_out !== 32'h1357_9BDF) $display("FAIL ackto_rdata: got %h want 13579bdf", rdata_out); else passed++;
    bus.bus_ack_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    bus.bus_ack_in   = 1'b1;
    bus.bus_rdata_in = 32'h1234_5678;
    issue(LOAD, 3'b010, 32'h0000_0100, 32'h0);
    tick();
    checks++; if (rdata_out !== 32'h1234_5678) $display("FAIL b2b_lw: got %h want 12345678", rdata_out); else passed++;
    tick();
    bus.bus_rdata_in = 32'h8001_0000;
    issue(LOAD, 3'b001, 32'h0000_0102, 32'h0);
    checks++; if (bus.bus_mask_out !== 4'b1100) $display("FAIL b2b_lh_mask: got %b want 1100", bus.bus_mask_out); else passed++;
    tick();
    checks++; if ({done_out, fault_out} !== 2'b10) $display("FAIL b2b_lh_done: got %b want 10", {done_out, fault_out}); else passed++;
    checks++; if (rdata_out !== 32'hFFFF_8001) $display("FAIL b2b_lh_rdata: got %h want ffff8001", rdata_out); else passed++;
    bus.bus_ack_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op;
    int dones = 0;
    bus.bus_ack_in = 1'b0;
    issue(LOAD, 3'b010, 32'h0000_0200, 32'h0);
    tick();
    issue(STORE, 3'b000, 32'h0000_0333, 32'hFFFF_FFFF);
    checks++; if ({busy_out, bus.bus_req_out, bus.bus_we_out} !== 3'b110) $display("FAIL mid_ignore_start: got %b want 110", {busy_out, bus.bus_req_out, bus.bus_we_out}); else passed++;
    checks++; if (bus.bus_addr_out !== 32'h0000_0200) $display("FAIL mid_addr_stable: got %h want 00000200", bus.bus_addr_out); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy_out, done_out, fault_out, bus.bus_req_out} !== 4'b0000) $display("FAIL mid_rst_ctl: got %b want 0000", {busy_out, done_out, fault_out, bus.bus_req_out}); else passed++;
    checks++; if ({rdata_out, bus.bus_addr_out, bus.bus_mask_out} !== 68'h0) $display("FAIL mid_rst_data: got %h want 0", {rdata_out, bus.bus_addr_out, bus.bus_mask_out}); else passed++;
    bus.bus_ack_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_out === 1'b1) dones++;
    end
    bus.bus_ack_in = 1'b0;
    checks++; if (dones !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", dones); else passed++;
  endtask

  initial begin
    reset            = 1'b1;
    start_in         = 1'b0;
    opcode_in        = 5'h0;
    funct3_in        = 3'h0;
    addr_in          = 32'h0;
    wdata_in         = 32'h0;
    bus.bus_ack_in   = 1'b0;
    bus.bus_rdata_in = 32'h0;
    test_reset();
    test_lb_immediate();
    test_lhu_wait();
    test_stores();
    test_faults();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
